// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer slice.
// Holds the default geometry of the tap-delay regfile and the sequencer
// state encoding.
package fir_pkg;

  localparam int DEPTH  = 64;  // regfile entries / circular buffer size
  localparam int WIDTH  = 16;  // signed sample width
  localparam int ADDR_W = 6;   // regfile address width, DEPTH == 2**ADDR_W
  localparam int NTAPS  = 64;  // taps read per frame, 1..DEPTH

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
// Accepts one sample per frame, writes it into the tap-delay regfile as a
// circular buffer, then reads NTAPS entries newest-first and streams them
// (with tap index and last flag) to the MAC.
//
// Ports:
//   clk2       sole clock, rising edge
//   rst        synchronous active-high reset
//   flush      synchronous history clear (same effect as rst)
//   s_valid    input sample valid
//   s_ready    sequencer can accept a sample
//   s_data     input sample
//   rf_wen     regfile write enable
//   rf_waddr   regfile write address
//   rf_din     regfile write data
//   rf_ren     regfile read enable
//   rf_raddr   regfile read address
//   rf_dout    regfile registered read data (1-cycle latency)
//   m_valid    tap sample valid (no backpressure)
//   m_data     tap sample, 0 for taps not yet filled
//   m_tap      tap index, 0 = newest
//   m_last     high with m_valid on tap NTAPS-1
module fir_tap_sequencer #(
  parameter int DEPTH  = fir_pkg::DEPTH,
  parameter int WIDTH  = fir_pkg::WIDTH,
  parameter int ADDR_W = fir_pkg::ADDR_W,
  parameter int NTAPS  = fir_pkg::NTAPS
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_din,
  output logic              rf_ren,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [WIDTH-1:0]  rf_dout,
  output logic              m_valid,
  output logic [WIDTH-1:0]  m_data,
  output logic [ADDR_W-1:0] m_tap,
  output logic              m_last
);
  import fir_pkg::*;

  localparam int                FILL_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NTAPS);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   wptr, wptr_n;
  logic [ADDR_W-1:0]   k, k_n;
  logic [FILL_W-1:0]   fill, fill_n;
  logic [WIDTH-1:0]    sample, sample_n;
  logic                tap_ok;

  always_comb begin
    state_n  = state;
    wptr_n   = wptr;
    k_n      = k;
    fill_n   = fill;
    sample_n = sample;
    case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          sample_n = s_data;
          state_n  = WRITE;
        end
      end
      WRITE: begin
        fill_n  = (fill == FILL_MAX) ? fill : fill + 1'b1;
        k_n     = '0;
        state_n = READ;
      end
      READ: begin
        if (k == LAST_K) state_n = DRAIN;
        else             k_n     = k + 1'b1;
      end
      DRAIN: begin
        wptr_n  = (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe. The m_* stage is the read request delayed one
  // cycle, matching the regfile's registered dout.
  always_ff @(posedge clk2) begin
    if (rst || flush) begin
      state    <= IDLE;
      wptr     <= '0;
      k        <= '0;
      fill     <= '0;
      sample   <= '0;
      s_ready  <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_din   <= '0;
      rf_ren   <= 1'b0;
      rf_raddr <= '0;
      m_valid  <= 1'b0;
      m_tap    <= '0;
      m_last   <= 1'b0;
      tap_ok   <= 1'b0;
    end else begin
      state    <= state_n;
      wptr     <= wptr_n;
      k        <= k_n;
      fill     <= fill_n;
      sample   <= sample_n;
      s_ready  <= (state_n == IDLE);
      rf_wen   <= (state_n == WRITE);
      rf_waddr <= wptr_n;
      rf_din   <= sample_n;
      rf_ren   <= (state_n == READ);
      rf_raddr <= wptr_n - k_n;
      m_valid  <= rf_ren;
      m_tap    <= k;
      m_last   <= rf_ren && (k == LAST_K);
      tap_ok   <= rf_ren && ({1'b0, k} < fill);
    end
  end

  // rf_dout is already a register; the mask select is registered alongside
  // m_valid, so m_data adds only a mux after the regfile output.
  always_comb begin
    m_data = tap_ok ? rf_dout : '0;
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed self-checking bench for fir_tap_sequencer with a behavioural
// 64x16 regfile (registered read) beside it.
module tb_fir_tap_sequencer;

  logic        clk2 = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        rf_wen;
  logic [5:0]  rf_waddr;
  logic [15:0] rf_din;
  logic        rf_ren;
  logic [5:0]  rf_raddr;
  logic [15:0] rf_dout = 16'hDEAD;
  logic        m_valid;
  logic [15:0] m_data;
  logic [5:0]  m_tap;
  logic        m_last;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk2 = ~clk2;

  fir_tap_sequencer #(
    .DEPTH (64),
    .WIDTH (16),
    .ADDR_W(6),
    .NTAPS (64)
  ) dut (
    .clk2    (clk2),
    .rst     (rst),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .rf_wen  (rf_wen),
    .rf_waddr(rf_waddr),
    .rf_din  (rf_din),
    .rf_ren  (rf_ren),
    .rf_raddr(rf_raddr),
    .rf_dout (rf_dout),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_tap   (m_tap),
    .m_last  (m_last)
  );

  // Regfile model: unwritten entries read back as 0xDEAD so the fill mask
  // is actually exercised.
  logic [15:0] mem [64];
  bit   [63:0] written;

  always @(posedge clk2) begin
    if (rf_wen) begin
      mem[rf_waddr]     <= rf_din;
      written[rf_waddr] <= 1'b1;
    end
    if (rf_ren) rf_dout <= written[rf_raddr] ? mem[rf_raddr] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-frame observations
  int          wen_cnt, wen_cyc, ren_cnt, ren_first, mv_cnt, mv_first;
  int          last_cnt, last_tap, ready_cyc, tap_order_err;
  logic [5:0]  waddr_seen;
  logic [15:0] din_seen;
  logic [15:0] dat [64];
  logic [5:0]  rad [64];

  function automatic int nonzero_from(input int from);
    int n = 0;
    for (int i = from; i < 64; i++) if (dat[i] != 16'h0) n++;
    return n;
  endfunction

  // Called at a negedge; offers v and records one complete frame.
  task automatic run_frame(input logic [15:0] v);
    int  cyc;
    int  w;
    bit  done;
    wen_cnt = 0; wen_cyc = -1; ren_cnt = 0; ren_first = -1;
    mv_cnt = 0; mv_first = -1; last_cnt = 0; last_tap = -1;
    ready_cyc = -1; tap_order_err = 0; waddr_seen = '0; din_seen = '0;
    for (int i = 0; i < 64; i++) begin
      dat[i] = 16'hBEEF;
      rad[i] = '0;
    end
    s_valid = 1'b1;
    s_data  = v;
    w = 0;
    while (!s_ready && w < 200) begin
      @(negedge clk2);
      w++;
    end
    check("frame_ready", s_ready, 1);
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk2);
      s_valid = 1'b0;
      cyc++;
      if (rf_wen) begin
        wen_cnt++; wen_cyc = cyc; waddr_seen = rf_waddr; din_seen = rf_din;
      end
      if (rf_ren) begin
        if (ren_first < 0) ren_first = cyc;
        if (ren_cnt < 64) rad[ren_cnt] = rf_raddr;
        ren_cnt++;
      end
      if (m_valid) begin
        if (mv_first < 0) mv_first = cyc;
        if (m_tap != 6'(mv_cnt)) tap_order_err++;
        dat[m_tap] = m_data;
        mv_cnt++;
      end
      if (m_last) begin
        last_cnt++;
        last_tap = m_tap;
      end
      if (s_ready) begin
        ready_cyc = cyc;
        done = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk2);
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (3) begin
      @(negedge clk2);
      check("rst_ctrl", {s_ready, rf_wen, rf_ren, m_valid, m_last, m_tap, rf_waddr, rf_raddr}, 0);
      check("rst_data", {rf_din, m_data}, 0);
    end
    rst = 1'b0;
    @(negedge clk2);
    check("rdy_after_rst", s_ready, 1);
    check("wen_after_rst", rf_wen, 0);
  endtask

  task automatic abort_test(input bit use_rst, input string nm);
    int mv, ml;
    check({nm, "_start_rdy"}, s_ready, 1);
    s_valid = 1'b1;
    s_data  = 16'h0077;
    @(negedge clk2);               // cycle 1: WRITE
    s_valid = 1'b0;
    repeat (11) @(negedge clk2);   // cycle 12: READ k=10
    check({nm, "_pre_ren"}, rf_ren, 1);
    check({nm, "_pre_tap"}, {m_valid, m_tap}, {1'b1, 6'd9});
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk2);
    rst = 1'b0;
    flush = 1'b0;
    check({nm, "_drop"}, {m_valid, m_last, rf_ren, rf_wen, s_ready}, 0);
    mv = 0; ml = 0;
    repeat (80) begin
      @(negedge clk2);
      if (m_valid) mv++;
      if (m_last) ml++;
    end
    check({nm, "_no_tail"}, mv, 0);
    check({nm, "_no_last"}, ml, 0);
    run_frame(16'h0009);
    check({nm, "_waddr"}, waddr_seen, 0);
    check({nm, "_tap0"}, dat[0], 16'h0009);
    check({nm, "_zeros"}, nonzero_from(1), 0);
    check({nm, "_mv_cnt"}, mv_cnt, 64);
  endtask

  initial begin
    int hs, wens, prev_wen, gap_err, w;
    logic [15:0] acc;

    // 1. reset
    do_reset();

    // 2. first sample
    run_frame(16'h0005);
    check("t2_wen_cnt", wen_cnt, 1);
    check("t2_wen_cyc", wen_cyc, 1);
    check("t2_waddr", waddr_seen, 0);
    check("t2_din", din_seen, 16'h0005);
    check("t2_ren_first", ren_first, 2);
    check("t2_ren_cnt", ren_cnt, 64);
    check("t2_mv_first", mv_first, 3);
    check("t2_mv_cnt", mv_cnt, 64);
    check("t2_tap_order", tap_order_err, 0);
    check("t2_tap0", dat[0], 16'h0005);
    check("t2_zeros", nonzero_from(1), 0);
    check("t2_last_cnt", last_cnt, 1);
    check("t2_last_tap", last_tap, 63);
    check("t2_ready_cyc", ready_cyc, 67);

    // 3. four back-to-back frames from empty history
    do_reset();
    for (int n = 1; n <= 4; n++) run_frame(16'(n));
    check("t3_waddr", waddr_seen, 3);
    check("t3_tap0", dat[0], 16'd4);
    check("t3_tap1", dat[1], 16'd3);
    check("t3_tap2", dat[2], 16'd2);
    check("t3_tap3", dat[3], 16'd1);
    check("t3_zeros", nonzero_from(4), 0);

    // 4. wrap-around over 70 frames
    do_reset();
    for (int n = 1; n <= 70; n++) run_frame(16'(n));
    check("t4_waddr", waddr_seen, 5);
    check("t4_raddr0", rad[0], 5);
    check("t4_tap0", dat[0], 16'd70);
    check("t4_raddr6", rad[6], 63);
    check("t4_tap6", dat[6], 16'd64);
    check("t4_raddr63", rad[63], 6);
    check("t4_tap63", dat[63], 16'd7);

    // 5. s_valid held high with changing data
    hs = 0; wens = 0; prev_wen = -1; gap_err = 0; acc = '0;
    s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      s_data = 16'h1000 + 16'(i);
      if (s_ready) begin
        hs++;
        acc = s_data;
      end
      @(negedge clk2);
      if (rf_wen) begin
        wens++;
        check("t5_din", rf_din, acc);
        if (prev_wen >= 0 && i - prev_wen != 67) gap_err++;
        prev_wen = i;
      end
    end
    s_valid = 1'b0;
    check("t5_hs", hs, 3);
    check("t5_wens", wens, 3);
    check("t5_gap", gap_err, 0);
    w = 0;
    while (!s_ready && w < 100) begin
      @(negedge clk2);
      w++;
    end
    check("t5_idle", s_ready, 1);

    // 6. abort mid-frame via flush, then via rst
    abort_test(1'b0, "t6_flush");
    abort_test(1'b1, "t6_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
